// File: rtl/sram_1rw_port_ctrl.sv
// sram_1rw_port_ctrl
//
// Request/response front end for a single-port 1RW OpenRAM macro. Valid/ready
// read and write requests are turned into registered macro pin activity. Read
// data is captured off the shared tri-state bus one cycle after the pin cycle
// and queued in a small response FIFO. Reads are only accepted when a FIFO slot
// is guaranteed for them.
//
// Optional feature: define SRAM_CTRL_RANGE_EN to enable the address range check
// (req_addr >= WORDS) and the rsp_err port.
//
// Ports:
//   clk, rstb          clock (also the macro clock), async active-low reset
//   req_valid/ready    request handshake; req_we selects write (1) or read (0)
//   req_addr/wdata     request word address and write data
//   rsp_valid/ready    response handshake (FIFO head)
//   rsp_rdata          read data
//   rsp_err            out-of-range flag (SRAM_CTRL_RANGE_EN only)
//   ADDR,CSb,WEb,OEb   registered macro address and active-low controls
//   DATA               macro data bus, driven only during write cycles

module sram_1rw_port_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WORDS      = 256,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef SRAM_CTRL_RANGE_EN
    output logic                  rsp_err,
`endif
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic                  CSb,
    output logic                  WEb,
    output logic                  OEb,
    inout  wire  [DATA_WIDTH-1:0] DATA
);

    localparam int unsigned PtrW = $clog2(RSP_DEPTH);
    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [CntW:0]   inf_t;

    // P-stage contents. PErrRd is an out-of-range read: idle pins, but it still
    // travels through C so an error response is returned in order.
    typedef enum logic [2:0] {PIdle, PRead, PWrite, PTurn, PErrRd} p_state_e;

    if (64'(WORDS) > (64'd1 << ADDR_WIDTH)) begin : g_words_too_big
        $error("WORDS exceeds 2**ADDR_WIDTH");
    end

    p_state_e              p_q, p_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  drive_q, drive_d;
    logic                  cs_d, we_d, oe_d;
    logic                  c_rd_q, c_err_q;

    logic                  in_range;
    logic                  p_has_rd;
    logic                  c_busy;
    inf_t                  inflight;
    logic                  credit_ok;
    logic                  accept;

    // Response FIFO
    logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
`ifdef SRAM_CTRL_RANGE_EN
    logic                  fifo_err  [RSP_DEPTH];
`endif
    ptr_t                  wr_ptr_q, rd_ptr_q;
    cnt_t                  count_q;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] push_data;

`ifdef SRAM_CTRL_RANGE_EN
    assign in_range = 64'(req_addr) < 64'(WORDS);
`else
    assign in_range = 1'b1;
`endif

    assign p_has_rd  = (p_q == PRead) || (p_q == PErrRd);
    assign c_busy    = c_rd_q | c_err_q;
    // Every read already in the pipe owns a FIFO slot before a new one enters.
    assign inflight  = inf_t'(count_q) + inf_t'(p_has_rd) + inf_t'(c_busy);
    assign credit_ok = inflight < inf_t'(RSP_DEPTH);

    // A write cannot follow a macro read directly: the macro still drives DATA
    // during the capture cycle.
    assign req_ready = rstb & (req_we ? (p_q != PRead) : credit_ok);
    assign accept    = req_valid & req_ready;

    always_comb begin
        p_d     = PIdle;
        addr_d  = ADDR;
        wdata_d = wdata_q;
        drive_d = 1'b0;
        cs_d    = 1'b1;
        we_d    = 1'b1;
        oe_d    = 1'b1;

        if (accept) begin
            if (!in_range) begin
                p_d = req_we ? PIdle : PErrRd;
            end else if (req_we) begin
                p_d     = PWrite;
                addr_d  = req_addr;
                wdata_d = req_wdata;
            end else begin
                p_d    = PRead;
                addr_d = req_addr;
            end
        end else if (p_q == PRead) begin
            // Keep the macro outputs enabled while the read is being captured.
            p_d = PTurn;
        end

        unique case (p_d)
            PRead, PTurn: begin
                cs_d = 1'b0;
                oe_d = 1'b0;
            end
            PWrite: begin
                cs_d    = 1'b0;
                we_d    = 1'b0;
                drive_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            p_q     <= PIdle;
            ADDR    <= '0;
            CSb     <= 1'b1;
            WEb     <= 1'b1;
            OEb     <= 1'b1;
            wdata_q <= '0;
            drive_q <= 1'b0;
            c_rd_q  <= 1'b0;
            c_err_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            ADDR    <= addr_d;
            CSb     <= cs_d;
            WEb     <= we_d;
            OEb     <= oe_d;
            wdata_q <= wdata_d;
            drive_q <= drive_d;
            c_rd_q  <= (p_q == PRead);
            c_err_q <= (p_q == PErrRd);
        end
    end

    assign DATA = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    assign push      = c_busy;
    assign push_data = c_err_q ? '0 : DATA;
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = fifo_data[rd_ptr_q];
`ifdef SRAM_CTRL_RANGE_EN
    assign rsp_err   = fifo_err[rd_ptr_q];
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                fifo_data[i] <= '0;
`ifdef SRAM_CTRL_RANGE_EN
                fifo_err[i]  <= 1'b0;
`endif
            end
        end else begin
            // Credit check guarantees a push never finds the FIFO full.
            if (push) begin
                fifo_data[wr_ptr_q] <= push_data;
`ifdef SRAM_CTRL_RANGE_EN
                fifo_err[wr_ptr_q]  <= c_err_q;
`endif
                wr_ptr_q <= (wr_ptr_q == ptr_t'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == ptr_t'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + ptr_t'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// Self-checking bench for sram_1rw_port_ctrl with a behavioural 1RW macro model.
module tb_sram_1rw_port_ctrl;

    logic       clk;
    logic       rstb;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
`ifdef SRAM_CTRL_RANGE_EN
    logic       rsp_err;
`endif
    logic [7:0] ADDR;
    logic       CSb, WEb, OEb;
    wire  [7:0] DATA;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef SRAM_CTRL_RANGE_EN
    sram_1rw_port_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .WORDS(200), .RSP_DEPTH(4)
    ) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .ADDR(ADDR), .CSb(CSb), .WEb(WEb), .OEb(OEb), .DATA(DATA)
    );
`else
    sram_1rw_port_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .WORDS(256), .RSP_DEPTH(4)
    ) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ADDR(ADDR), .CSb(CSb), .WEb(WEb), .OEb(OEb), .DATA(DATA)
    );
`endif

    // Macro model: write and read sampled on the rising edge, output driven
    // while CSb=0, OEb=0, WEb=1.
    logic [7:0] mem [256];
    logic [7:0] dout;

    always @(posedge clk) begin
        if (!CSb && !WEb) mem[ADDR] <= DATA;
        if (!CSb && WEb) dout <= mem[ADDR];
    end

    assign DATA = (!CSb && !OEb && WEb) ? dout : 8'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Both sides would drive DATA if a write cycle also enabled macro outputs.
    always @(negedge clk) begin
        if (rstb) chk("bus_contention", {31'd0, (!CSb && !WEb && !OEb)}, 32'd0);
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_req(input logic we, input logic [7:0] a, input logic [7:0] d);
        bit done = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("req_accept_timeout", {31'd0, done}, 32'd1);
    endtask

    // Expects rsp_ready=1; returns just after the popping edge.
    task automatic wait_rsp(input string name, input logic [7:0] exp_d, input logic exp_e);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        chk({name, "_valid"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk({name, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp_d});
`ifdef SRAM_CTRL_RANGE_EN
            chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
`endif
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int   acc;
        int   a;
        bit   stale;

        vecs[0] = '{1'b1, 8'h10, 8'h5A, 8'h00};
        vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h5A};
        vecs[2] = '{1'b1, 8'h20, 8'hA5, 8'h00};
        vecs[3] = '{1'b1, 8'h21, 8'h3C, 8'h00};
        vecs[4] = '{1'b0, 8'h21, 8'h00, 8'h3C};
        vecs[5] = '{1'b0, 8'h20, 8'h00, 8'hA5};
        vecs[6] = '{1'b1, 8'h10, 8'hFF, 8'h00};
        vecs[7] = '{1'b0, 8'h10, 8'h00, 8'hFF};
        vecs[8] = '{1'b1, 8'hC7, 8'h81, 8'h00};
        vecs[9] = '{1'b0, 8'hC7, 8'h00, 8'h81};

        // Reset state, with a request pending so req_ready is exercised.
        rstb      = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b0;
        #12;
        chk("rst_CSb", {31'd0, CSb}, 32'd1);
        chk("rst_WEb", {31'd0, WEb}, 32'd1);
        chk("rst_OEb", {31'd0, OEb}, 32'd1);
        chk("rst_ADDR", {24'd0, ADDR}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // Table of single transactions.
        rsp_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            do_req(vecs[v].we, vecs[v].addr, vecs[v].wdata);
            if (!vecs[v].we) wait_rsp("tbl_rd", vecs[v].exp, 1'b0);
        end

        // Write 0x5A to 0x10 at edge k, read 0x10 at edge k+1.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h5A;
        @(negedge clk);
        chk("wr_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_we = 1'b0;
        @(negedge clk);
        chk("wr_pin_CSb", {31'd0, CSb}, 32'd0);
        chk("wr_pin_WEb", {31'd0, WEb}, 32'd0);
        chk("wr_pin_OEb", {31'd0, OEb}, 32'd1);
        chk("wr_pin_ADDR", {24'd0, ADDR}, 32'h10);
        chk("war_rd_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rd_pin_WEb", {31'd0, WEb}, 32'd1);
        chk("rd_pin_OEb", {31'd0, OEb}, 32'd0);
        chk("rd_k2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("turn_pin_CSb", {31'd0, CSb}, 32'd0);
        chk("turn_pin_OEb", {31'd0, OEb}, 32'd0);
        chk("turn_pin_ADDR", {24'd0, ADDR}, 32'h10);
        chk("rd_k3_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rd_k4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_k4_rsp_rdata", {24'd0, rsp_rdata}, 32'h5A);
        @(posedge clk); #1;

        // Back-to-back reads of i*3.
        for (int i = 0; i < 8; i++) do_req(1'b1, 8'(i), 8'(i * 3));
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(i);
                    @(negedge clk);
                    chk("burst_req_ready", {31'd0, req_ready}, 32'd1);
                    @(posedge clk); #1;
                end
                req_valid = 1'b0;
            end
            begin
                bit got = 0;
                for (int t = 0; t < 20 && !got; t++) begin
                    @(negedge clk);
                    if (rsp_valid) got = 1;
                end
                chk("burst_first_valid", {31'd0, got}, 32'd1);
                if (got) begin
                    chk("burst_rdata", {24'd0, rsp_rdata}, 32'd0);
                    for (int n = 1; n < 8; n++) begin
                        @(negedge clk);
                        chk("burst_valid", {31'd0, rsp_valid}, 32'd1);
                        chk("burst_rdata", {24'd0, rsp_rdata}, 32'(n * 3));
                    end
                end
            end
        join
        @(posedge clk); #1;

        // Read then write on consecutive requests: one bubble, old value read.
        do_req(1'b1, 8'h30, 8'h11);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h30;
        @(negedge clk);
        chk("rw_rd_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_we = 1'b1; req_wdata = 8'h22;
        @(negedge clk);
        chk("rw_bubble", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_wr_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp("rw_old", 8'h11, 1'b0);
        do_req(1'b0, 8'h30, 8'h00);
        wait_rsp("rw_new", 8'h22, 1'b0);

        // Backpressure: exactly RSP_DEPTH reads accepted, then in-order drain.
        rsp_ready = 1'b0;
        acc = 0;
        a = 1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(a);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready) begin
                acc++;
                a++;
            end
            @(posedge clk); #1;
            req_addr = 8'(a);
        end
        chk("bp_accepted", 32'(acc), 32'd4);
        @(negedge clk);
        chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_hold_rdata", {24'd0, rsp_rdata}, 32'd3);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_drain_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_drain_rdata", {24'd0, rsp_rdata}, 32'((i + 1) * 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_empty", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a read burst with responses pending.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
        repeat (3) @(posedge clk);
        #2;
        rstb = 1'b0;
        #1;
        chk("mid_rst_CSb", {31'd0, CSb}, 32'd1);
        chk("mid_rst_WEb", {31'd0, WEb}, 32'd1);
        chk("mid_rst_OEb", {31'd0, OEb}, 32'd1);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        rsp_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) stale = 1;
        end
        chk("mid_rst_no_stale", {31'd0, stale}, 32'd0);
        @(posedge clk); #1;
        do_req(1'b0, 8'h05, 8'h00);
        wait_rsp("post_rst_rd", 8'd15, 1'b0);

`ifdef SRAM_CTRL_RANGE_EN
        // Out-of-range requests with WORDS=200.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd250;
        @(negedge clk);
        chk("rng_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rng_CSb_idle", {31'd0, CSb}, 32'd1);
        wait_rsp("rng_rd250", 8'h00, 1'b1);
        do_req(1'b1, 8'd250, 8'h77);
        do_req(1'b0, 8'd250, 8'h00);
        wait_rsp("rng_rd250_after_wr", 8'h00, 1'b1);
        do_req(1'b0, 8'd200, 8'h00);
        wait_rsp("rng_rd200", 8'h00, 1'b1);
        do_req(1'b0, 8'd199, 8'h00);
        wait_rsp("rng_rd199", 8'h81, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
